// File: rtl/cpu_types_pkg.sv
// -----------------------------------------------------------------------------
// cpu_types_pkg
// Shared CPU types used by the instruction cache:
//   word_t          32-bit machine word
//   icache_frame_t  one cache frame {valid, tag, data}; the tag field is sized
//                   for the widest tag (SETS=2) and narrower tags are stored
//                   zero-extended
//   icachef_t       fetch address split for the default SETS=16 geometry
//   icache_state_t  cache controller states {IDLE, FETCH}
//   word_align()    clears the byte offset of an address
// -----------------------------------------------------------------------------
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    // Widest tag occurs at the minimum of two sets: 32 - 1 index bit - 2 offset bits.
    localparam int ICACHE_TAG_MAX_W = 29;

    typedef struct packed {
        logic                        valid;
        logic [ICACHE_TAG_MAX_W-1:0] tag;
        word_t                       data;
    } icache_frame_t;

    typedef struct packed {
        logic [25:0] tag;
        logic [3:0]  idx;
        logic [1:0]  bytoff;
    } icachef_t;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } icache_state_t;

    function automatic word_t word_align(input word_t addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/icache_frames.sv
// -----------------------------------------------------------------------------
// icache_frames
// Direct-mapped frame store: combinational read by index, one synchronous
// write port. Valid bits clear asynchronously on nRST; tag/data are left
// unreset because a cleared valid bit makes their contents irrelevant.
// Ports:
//   CLK, nRST          clock, asynchronous active-low reset
//   rd_idx             read index
//   rd_valid/tag/data  frame contents at rd_idx
//   wr_en, wr_idx      write strobe and index
//   wr_tag, wr_data    tag (zero-extended) and word written on wr_en
// -----------------------------------------------------------------------------
module icache_frames
    import cpu_types_pkg::*;
#(
    parameter int SETS  = 16,
    parameter int IDX_W = $clog2(SETS)
) (
    input  logic                        CLK,
    input  logic                        nRST,
    input  logic [IDX_W-1:0]            rd_idx,
    output logic                        rd_valid,
    output logic [ICACHE_TAG_MAX_W-1:0] rd_tag,
    output logic [31:0]                 rd_data,
    input  logic                        wr_en,
    input  logic [IDX_W-1:0]            wr_idx,
    input  logic [ICACHE_TAG_MAX_W-1:0] wr_tag,
    input  logic [31:0]                 wr_data
);

    logic [SETS-1:0]             valid_r;
    logic [ICACHE_TAG_MAX_W-1:0] tag_r [SETS];
    word_t                       data_r [SETS];
    icache_frame_t               frame_s;

    // Valid bits: cleared by reset, set when a fill is written.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_r <= {SETS{1'b0}};
        end else if (wr_en) begin
            valid_r[wr_idx] <= 1'b1;
        end
    end

    // Tag and data storage, written only by a completing fill.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            tag_r[wr_idx]  <= wr_tag;
            data_r[wr_idx] <= wr_data;
        end
    end

    // Combinational read of the addressed frame.
    always_comb begin
        frame_s.valid = valid_r[rd_idx];
        frame_s.tag   = tag_r[rd_idx];
        frame_s.data  = data_r[rd_idx];
        rd_valid      = frame_s.valid;
        rd_tag        = frame_s.tag;
        rd_data       = frame_s.data;
    end

endmodule

// File: rtl/icache.sv
// -----------------------------------------------------------------------------
// icache
// Direct-mapped, one-word-per-frame, read-only instruction cache with a
// two-state miss FSM (IDLE/FETCH). Hits are combinational; a miss latches the
// word address and holds the memory-controller request until iwait drops,
// even if the datapath withdraws or changes its request meanwhile.
// Optional build macro: ICACHE_STATS_EN adds hit_count/miss_count.
// Ports:
//   CLK, nRST           clock, asynchronous active-low reset
//   imemREN, imemaddr   datapath fetch request and byte address
//   ihit, imemload      hit indication and instruction word
//   iREN, iaddr         fill request and word-aligned fill address
//   iwait, iload        controller busy flag and fill word
//   hit_count           (ICACHE_STATS_EN) cycles with ihit=1
//   miss_count          (ICACHE_STATS_EN) IDLE->FETCH transitions
// -----------------------------------------------------------------------------
module icache
    import cpu_types_pkg::*;
#(
    parameter int SETS = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int IDX_W = $clog2(SETS);

    icache_state_t               state_r;
    icache_state_t               next_state_s;
    word_t                       miss_addr_r;
    logic [IDX_W-1:0]            idx_s;
    logic [ICACHE_TAG_MAX_W-1:0] tag_s;
    logic                        fr_valid_s;
    logic [ICACHE_TAG_MAX_W-1:0] fr_tag_s;
    word_t                       fr_data_s;
    logic                        hit_s;
    logic                        miss_start_s;
    logic                        fill_s;

    assign idx_s = imemaddr[IDX_W+1:2];
    assign tag_s = ICACHE_TAG_MAX_W'(imemaddr[31:IDX_W+2]);
    assign hit_s = fr_valid_s && (fr_tag_s == tag_s);

    icache_frames #(
        .SETS  (SETS),
        .IDX_W (IDX_W)
    ) u_frames (
        .CLK      (CLK),
        .nRST     (nRST),
        .rd_idx   (idx_s),
        .rd_valid (fr_valid_s),
        .rd_tag   (fr_tag_s),
        .rd_data  (fr_data_s),
        .wr_en    (fill_s),
        .wr_idx   (miss_addr_r[IDX_W+1:2]),
        .wr_tag   (ICACHE_TAG_MAX_W'(miss_addr_r[31:IDX_W+2])),
        .wr_data  (iload)
    );

    // FSM state register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state: a missed request starts a fill; a fill ends when iwait drops.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (imemREN && !hit_s) begin
                    next_state_s = FETCH;
                end else begin
                    next_state_s = IDLE;
                end
            end
            FETCH: begin
                if (!iwait) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = FETCH;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // FSM outputs: hit path in IDLE, controller handshake in FETCH.
    always_comb begin
        ihit     = 1'b0;
        imemload = 32'h0000_0000;
        iREN     = 1'b0;
        iaddr    = 32'h0000_0000;
        fill_s   = 1'b0;
        case (state_r)
            IDLE: begin
                ihit     = imemREN && hit_s;
                imemload = (imemREN && hit_s) ? fr_data_s : 32'h0000_0000;
            end
            FETCH: begin
                iREN   = 1'b1;
                iaddr  = miss_addr_r;
                fill_s = !iwait;
            end
            default: begin
                ihit = 1'b0;
            end
        endcase
    end

    assign miss_start_s = (state_r == IDLE) && (next_state_s == FETCH);

    // Miss address capture on the IDLE->FETCH edge; held through the fill.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            miss_addr_r <= 32'h0000_0000;
        end else if (miss_start_s) begin
            miss_addr_r <= word_align(imemaddr);
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_r;
    logic [31:0] miss_cnt_r;

    // Free-running wrap-around hit/miss statistics.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hit_cnt_r  <= 32'h0000_0000;
            miss_cnt_r <= 32'h0000_0000;
        end else begin
            if (ihit) begin
                hit_cnt_r <= hit_cnt_r + 32'd1;
            end
            if (miss_start_s) begin
                miss_cnt_r <= miss_cnt_r + 32'd1;
            end
        end
    end

    assign hit_count  = hit_cnt_r;
    assign miss_count = miss_cnt_r;
`endif

endmodule
